lc3_reg_file_sb: RTL and testbench

Parametrised register file generalising the team's single 16-bit enabled/clearable register into a WIDTH×DEPTH array. It has two combinational read ports, one write port with optional write-to-read bypass, an LC-3 NZP condition-code register, and a per-register busy scoreboard for pipelined issue. It sits between decode (read/reserve) and writeback (write/ld_cc) in the LC-3 datapath.

---
 rtl/lc3_pkg.sv | 20 ++
 rtl/param_register.sv | 24 ++
 rtl/lc3_reg_file_sb.sv | 111 +++++++++++
 tb/tb_lc3_reg_file_sb.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: condition-code encodings and the NZP evaluation helper.
package lc3_pkg;

    localparam logic [2:0] CC_N     = 3'b100;
    localparam logic [2:0] CC_Z     = 3'b010;
    localparam logic [2:0] CC_P     = 3'b001;
    localparam logic [2:0] CC_RESET = CC_Z;

    // Callers pass the sign bit and an all-zero flag so this works for any word width.
    function automatic logic [2:0] calc_nzp(input logic sign, input logic zero);
        if (sign) begin
            return CC_N;
        end else if (zero) begin
            return CC_Z;
        end else begin
            return CC_P;
        end
    endfunction

endpackage

// File: rtl/param_register.sv
// Falling-edge register with load enable and synchronous active-high clear.
module param_register #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(negedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/lc3_reg_file_sb.sv
// LC-3 register file: 2 read / 1 write ports, optional write bypass, NZP register
// and a per-register busy scoreboard. All state changes on the falling edge.
module lc3_reg_file_sb
    import lc3_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 8,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    output logic             busy_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             busy_b,
    input  logic             rsv,
    input  logic [AW-1:0]    rsv_addr,
    input  logic             ld_cc,
    input  logic [WIDTH-1:0] cc_data,
    output logic [2:0]       nzp,
    output logic [DEPTH-1:0] busy
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] wen;
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [2:0]       nzp_q;
    logic             wr_valid;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_regs
        assign wen[gi] = we && (waddr == AW'(gi));

        param_register #(
            .WIDTH (WIDTH)
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (wen[gi]),
            .d     (wdata),
            .q     (regs[gi])
        );
    end

    // Out-of-range write addresses match no register, so they never reach the array.
    assign wr_valid = |wen;

    // A reservation in the same cycle as a write to that register wins.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wen[i]) begin
                busy_d[i] = 1'b0;
            end
            if (rsv && (rsv_addr == AW'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            busy_q <= '0;
            nzp_q  <= CC_RESET;
        end else begin
            busy_q <= busy_d;
            if (ld_cc) begin
                nzp_q <= calc_nzp(cc_data[WIDTH-1], cc_data == '0);
            end
        end
    end

    always_comb begin
        rdata_a = '0;
        busy_a  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_a == AW'(i)) begin
                rdata_a = regs[i];
                busy_a  = busy_q[i];
            end
        end
        if (BYPASS && wr_valid && (waddr == raddr_a)) begin
            rdata_a = wdata;
            busy_a  = 1'b0;
        end
    end

    always_comb begin
        rdata_b = '0;
        busy_b  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_b == AW'(i)) begin
                rdata_b = regs[i];
                busy_b  = busy_q[i];
            end
        end
        if (BYPASS && wr_valid && (waddr == raddr_b)) begin
            rdata_b = wdata;
            busy_b  = 1'b0;
        end
    end

    assign nzp  = nzp_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_lc3_reg_file_sb.sv
// Self-checking bench for lc3_reg_file_sb: default instance plus a DEPTH=6, no-bypass instance.
module tb_lc3_reg_file_sb;

    typedef struct {
        logic        we;
        logic [2:0]  waddr;
        logic [15:0] wdata;
        logic        rsv;
        logic [2:0]  rsv_addr;
        logic        ld_cc;
        logic [15:0] cc_data;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        logic        exp_ba;
        logic        exp_bb;
        logic [2:0]  exp_nzp;
        logic [7:0]  exp_busy;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ba;
        logic        bb;
        logic [2:0]  nzp;
        logic [7:0]  busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, we, rsv, ld_cc;
    logic [2:0]  waddr, raddr_a, raddr_b, rsv_addr;
    logic [15:0] wdata, cc_data;
    logic [15:0] rdata_a, rdata_b, r6_a, r6_b;
    logic        busy_a, busy_b, b6_a, b6_b;
    logic [2:0]  nzp, nzp6;
    logic [7:0]  busy;
    logic [5:0]  busy6;

    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [10];
    exp_t sb [$];
    exp_t e;

    always #5 clk = ~clk;

    lc3_reg_file_sb dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (raddr_a),
        .rdata_a  (rdata_a),
        .busy_a   (busy_a),
        .raddr_b  (raddr_b),
        .rdata_b  (rdata_b),
        .busy_b   (busy_b),
        .rsv      (rsv),
        .rsv_addr (rsv_addr),
        .ld_cc    (ld_cc),
        .cc_data  (cc_data),
        .nzp      (nzp),
        .busy     (busy)
    );

    lc3_reg_file_sb #(
        .WIDTH  (16),
        .DEPTH  (6),
        .BYPASS (1'b0)
    ) dut6 (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (raddr_a),
        .rdata_a  (r6_a),
        .busy_a   (b6_a),
        .raddr_b  (raddr_b),
        .rdata_b  (r6_b),
        .busy_b   (b6_b),
        .rsv      (rsv),
        .rsv_addr (rsv_addr),
        .ld_cc    (ld_cc),
        .cc_data  (cc_data),
        .nzp      (nzp6),
        .busy     (busy6)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0;
        we    = 1'b0;
        rsv   = 1'b0;
        ld_cc = 1'b0;
    endtask

    // Let the falling edge capture, then drop controls and settle mid-high-phase.
    task automatic edge_then_idle();
        @(negedge clk);
        @(posedge clk);
        idle();
        #1;
    endtask

    task automatic check_all_clear(input string tag);
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i);
            raddr_b = 3'(7 - i);
            #1;
            check($sformatf("%s.rd_a[%0d]", tag, i), 32'(rdata_a), 32'h0);
            check($sformatf("%s.rd_b[%0d]", tag, 7 - i), 32'(rdata_b), 32'h0);
            check($sformatf("%s.busy_a[%0d]", tag, i), 32'(busy_a), 32'h0);
        end
        check($sformatf("%s.busy", tag), 32'(busy), 32'h0);
        check($sformatf("%s.nzp", tag), 32'(nzp), 32'h2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          we    wa    wdata     rsv   ra    ld    cc        ra    rb    a         b         ba    bb    nzp     busy
        vecs[0] = '{1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 1'b0, 16'h0000, 3'd3, 3'd3, 16'h1234, 16'h1234, 1'b0, 1'b0, 3'b010, 8'h00};
        vecs[1] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 1'b0, 16'h0000, 3'd5, 3'd3, 16'h0000, 16'h1234, 1'b1, 1'b0, 3'b010, 8'h20};
        vecs[2] = '{1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 1'b0, 16'h0000, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 3'b010, 8'h00};
        vecs[3] = '{1'b1, 3'd5, 16'h5555, 1'b1, 3'd5, 1'b0, 16'h0000, 3'd5, 3'd5, 16'h5555, 16'h5555, 1'b1, 1'b1, 3'b010, 8'h20};
        vecs[4] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 16'h8000, 3'd0, 3'd7, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b100, 8'h20};
        vecs[5] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 16'h0000, 3'd3, 3'd0, 16'h1234, 16'h0000, 1'b0, 1'b0, 3'b010, 8'h20};
        vecs[6] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 16'h0001, 3'd5, 3'd3, 16'h5555, 16'h1234, 1'b1, 1'b0, 3'b001, 8'h20};
        vecs[7] = '{1'b1, 3'd7, 16'hFFFF, 1'b1, 3'd2, 1'b1, 16'h7FFF, 3'd7, 3'd2, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 3'b001, 8'h24};
        vecs[8] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b0, 16'h0000, 3'd3, 3'd2, 16'h1234, 16'h0000, 1'b0, 1'b1, 3'b001, 8'h24};
        vecs[9] = '{1'b1, 3'd2, 16'h0ABC, 1'b0, 3'd0, 1'b1, 16'h8001, 3'd5, 3'd2, 16'h5555, 16'h0ABC, 1'b1, 1'b0, 3'b100, 8'h20};

        idle();
        waddr = '0; wdata = '0; rsv_addr = '0; cc_data = '0; raddr_a = '0; raddr_b = '0;
        reset = 1'b1;
        @(posedge clk);
        edge_then_idle();
        check_all_clear("rst");

        for (int i = 0; i < 10; i++) begin
            we       = vecs[i].we;
            waddr    = vecs[i].waddr;
            wdata    = vecs[i].wdata;
            rsv      = vecs[i].rsv;
            rsv_addr = vecs[i].rsv_addr;
            ld_cc    = vecs[i].ld_cc;
            cc_data  = vecs[i].cc_data;
            raddr_a  = vecs[i].ra;
            raddr_b  = vecs[i].rb;
            sb.push_back('{vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_ba, vecs[i].exp_bb,
                           vecs[i].exp_nzp, vecs[i].exp_busy});
            edge_then_idle();
            e = sb.pop_front();
            check($sformatf("v%0d.rd_a", i), 32'(rdata_a), 32'(e.a));
            check($sformatf("v%0d.rd_b", i), 32'(rdata_b), 32'(e.b));
            check($sformatf("v%0d.busy_a", i), 32'(busy_a), 32'(e.ba));
            check($sformatf("v%0d.busy_b", i), 32'(busy_b), 32'(e.bb));
            check($sformatf("v%0d.nzp", i), 32'(nzp), 32'(e.nzp));
            check($sformatf("v%0d.busy", i), 32'(busy), 32'(e.busy));
        end

        // Reset wins over a simultaneous write, reserve and condition-code load.
        reset = 1'b1; we = 1'b1; waddr = 3'd4; wdata = 16'h1111;
        rsv = 1'b1; rsv_addr = 3'd1; ld_cc = 1'b1; cc_data = 16'h8000;
        edge_then_idle();
        check_all_clear("rst_mid");
        check("rst_mid.busy6", 32'(busy6), 32'h0);
        check("rst_mid.nzp6", 32'(nzp6), 32'h2);

        rsv = 1'b1; rsv_addr = 3'd3;
        edge_then_idle();

        // Same-cycle read of a write: forwarded on the bypass instance only.
        we = 1'b1; waddr = 3'd3; wdata = 16'h1234; raddr_a = 3'd3; raddr_b = 3'd3;
        #1;
        check("byp.rd_a", 32'(rdata_a), 32'h1234);
        check("byp.busy_a", 32'(busy_a), 32'h0);
        check("nobyp.rd_a", 32'(r6_a), 32'h0);
        check("nobyp.busy_a", 32'(b6_a), 32'h1);
        edge_then_idle();
        check("nobyp.after.rd_a", 32'(r6_a), 32'h1234);
        check("nobyp.after.rd_b", 32'(r6_b), 32'h1234);
        check("nobyp.after.busy6", 32'(busy6), 32'h0);
        check("byp.after.busy", 32'(busy), 32'h0);

        // Out-of-range write and reserve on DEPTH=6 leave no trace.
        we = 1'b1; waddr = 3'd7; wdata = 16'hFFFF; rsv = 1'b1; rsv_addr = 3'd7;
        raddr_a = 3'd7; raddr_b = 3'd3;
        edge_then_idle();
        check("oor.rd_a", 32'(r6_a), 32'h0);
        check("oor.busy_a", 32'(b6_a), 32'h0);
        check("oor.busy6", 32'(busy6), 32'h0);
        check("oor.rd_b", 32'(r6_b), 32'h1234);
        check("in8.busy", 32'(busy), 32'h80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
